// File: rtl/cpu_step_ctrl_pkg.sv
// Shared state/phase encodings for the CPU step controller and any debug/display decode.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_CHECK = 1'b1
    } phase_e;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Button/CPU-facing bundle of the step controller; master drives buttons and pc, slave is the controller.
interface cpu_step_ctrl_if
    import cpu_step_ctrl_pkg::*;
#(
    parameter int PC_WIDTH       = 16,
    parameter int STEP_CNT_WIDTH = 8
);
    logic                      step_btn;
    logic                      run_btn;
    logic                      halt_btn;
    logic                      bp_en;
    logic [PC_WIDTH-1:0]       bp_addr;
    logic [STEP_CNT_WIDTH-1:0] step_count;
    logic [PC_WIDTH-1:0]       pc;
    logic                      cpu_ce;
    state_e                    state;
    logic                      bp_hit;
    logic [STEP_CNT_WIDTH-1:0] steps_done;

    modport master (
        output step_btn, run_btn, halt_btn, bp_en, bp_addr, step_count, pc,
        input  cpu_ce, state, bp_hit, steps_done
    );

    modport slave (
        input  step_btn, run_btn, halt_btn, bp_en, bp_addr, step_count, pc,
        output cpu_ce, state, bp_hit, steps_done
    );
endinterface

// File: rtl/cpu_step_ctrl_run_tick_gen.sv
// Free-running WIDTH-bit divider: tick is high for the one cycle the count is all-ones.
// clr zeroes the count on the next edge; no backpressure.
module run_tick_gen #(
    parameter int WIDTH = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam logic [WIDTH-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = &cnt_q;
endmodule

// File: rtl/cpu_step_ctrl.sv
// Generates single-cycle CPU clock enables for step/run/halt/breakpoint control of the core.
// ISSUE is the cycle cpu_ce is high; CHECK follows it, when the CPU's new pc is visible.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int PC_WIDTH       = 16,
    parameter int RUN_DIV_WIDTH  = 19,
    parameter int STEP_CNT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    cpu_step_ctrl_if.slave  bus
);
    localparam logic [STEP_CNT_WIDTH-1:0] STEP_ONE = 1;

    state_e                    state_q, state_d;
    phase_e                    phase_q, phase_d;
    logic                      fresh_q, fresh_d;
    logic                      halt_pend_q, halt_pend_d;
    logic                      cpu_ce_q, cpu_ce_d;
    logic [STEP_CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [STEP_CNT_WIDTH-1:0] steps_done_q, steps_done_d;
    logic [2:0]                btn_prev_q, btn_prev_d;

    logic [2:0] btn_now, btn_edge;
    logic       step_e, run_e, halt_e;
    logic       bp_match, tick, tick_clr;
    logic       enter_step, enter_run, keep_fresh, issue;

    run_tick_gen #(.WIDTH(RUN_DIV_WIDTH)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign btn_now  = {bus.halt_btn, bus.run_btn, bus.step_btn};
    assign btn_edge = btn_now & ~btn_prev_q;
    assign step_e   = btn_edge[0];
    assign run_e    = btn_edge[1];
    assign halt_e   = btn_edge[2];
    assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        fresh_d      = fresh_q;
        halt_pend_d  = halt_pend_q;
        cpu_ce_d     = 1'b0;
        remaining_d  = remaining_q;
        steps_done_d = steps_done_q;
        btn_prev_d   = btn_now;
        tick_clr     = 1'b0;
        enter_step   = 1'b0;
        enter_run    = 1'b0;
        keep_fresh   = 1'b0;
        issue        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A halt edge in IDLE is a no-op but still masks run/step in that cycle.
                if (!halt_e) begin
                    if (run_e)       enter_run  = 1'b1;
                    else if (step_e) enter_step = 1'b1;
                end
            end
            ST_BREAK: begin
                if (halt_e)      state_d    = ST_IDLE;
                else if (run_e)  enter_run  = 1'b1;
                else if (step_e) enter_step = 1'b1;
            end
            ST_STEP, ST_RUN: begin
                if (phase_q == PH_ISSUE) begin
                    // The pulse is already out; its pc still gets compared in CHECK.
                    phase_d = PH_CHECK;
                    fresh_d = 1'b1;
                    if (halt_e) begin
                        halt_pend_d = 1'b1;
                    end else if (run_e && state_q == ST_STEP) begin
                        enter_run  = 1'b1;
                        keep_fresh = 1'b1;
                    end
                end else begin
                    fresh_d     = 1'b0;
                    halt_pend_d = 1'b0;
                    if (fresh_q && bp_match)                 state_d   = ST_BREAK;
                    else if (halt_e || halt_pend_q)          state_d   = ST_IDLE;
                    else if (run_e && state_q == ST_STEP)    enter_run = 1'b1;
                    else if (state_q == ST_STEP) begin
                        if (remaining_q == '0) state_d = ST_IDLE;
                        else                   issue   = 1'b1;
                    end
                    else if (tick)                           issue     = 1'b1;
                end
            end
        endcase

        if (enter_step || enter_run) begin
            state_d      = enter_run ? ST_RUN : ST_STEP;
            phase_d      = PH_CHECK;
            fresh_d      = keep_fresh;
            halt_pend_d  = 1'b0;
            steps_done_d = '0;
            tick_clr     = 1'b1;
        end
        if (enter_step) begin
            remaining_d = (bus.step_count == '0) ? STEP_ONE : bus.step_count;
        end

        if (issue) begin
            cpu_ce_d = 1'b1;
            phase_d  = PH_ISSUE;
            if (steps_done_q != '1) steps_done_d = steps_done_q + STEP_ONE;
            if (state_q == ST_STEP) remaining_d = remaining_q - STEP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_ISSUE;
            fresh_q      <= 1'b0;
            halt_pend_q  <= 1'b0;
            cpu_ce_q     <= 1'b0;
            remaining_q  <= '0;
            steps_done_q <= '0;
            btn_prev_q   <= btn_now;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            fresh_q      <= fresh_d;
            halt_pend_q  <= halt_pend_d;
            cpu_ce_q     <= cpu_ce_d;
            remaining_q  <= remaining_d;
            steps_done_q <= steps_done_d;
            btn_prev_q   <= btn_prev_d;
        end
    end

    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.state      = state_q;
    assign bus.bp_hit     = (state_q == ST_BREAK);
    assign bus.steps_done = steps_done_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with an 8-cycle run divider and a pc model stepping by 4 per pulse.
module tb_cpu_step_ctrl;
    import cpu_step_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [63:0] ce_tr;
    state_e      st_tr [64];
    logic [15:0] pc_model;

    always #5 clk = ~clk;

    cpu_step_ctrl_if bus ();

    cpu_step_ctrl #(
        .PC_WIDTH       (16),
        .RUN_DIV_WIDTH  (3),
        .STEP_CNT_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (rst)             pc_model <= 16'h0000;
        else if (bus.cpu_ce) pc_model <= pc_model + 16'd4;
    end
    assign bus.pc = pc_model;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Records cpu_ce/state for n cycles; buttons drop back low after the first edge.
    task automatic capture(input int n);
        ce_tr = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ce_tr[i]     = bus.cpu_ce;
            st_tr[i]     = bus.state;
            bus.step_btn = 1'b0;
            bus.run_btn  = 1'b0;
            bus.halt_btn = 1'b0;
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.step_btn   = 1'b1;
        bus.run_btn    = 1'b0;
        bus.halt_btn   = 1'b0;
        bus.bp_en      = 1'b0;
        bus.bp_addr    = 16'h0000;
        bus.step_count = 8'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",  32'(bus.state),  32'(ST_IDLE));
        chk("rst_ce",     32'(bus.cpu_ce), 32'd0);
        chk("rst_done",   32'(bus.steps_done), 32'd0);
        chk("rst_bphit",  32'(bus.bp_hit), 32'd0);
        rst = 1'b0;

        // Button held through reset must not count as a press.
        capture(4);
        chk("held_no_pulse", ce_tr[31:0], 32'h0);

        bus.step_btn = 1'b1;
        capture(6);
        chk("step1_trace", ce_tr[31:0], 32'h2);
        chk("step1_idle",  32'(st_tr[3]), 32'(ST_IDLE));
        chk("step1_done",  32'(bus.steps_done), 32'd1);

        bus.step_count = 8'd3;
        bus.step_btn   = 1'b1;
        capture(10);
        chk("step3_trace",  ce_tr[31:0], 32'h2A);
        chk("step3_t7",     32'(st_tr[6]), 32'(ST_STEP));
        chk("step3_t8",     32'(st_tr[7]), 32'(ST_IDLE));
        chk("step3_done",   32'(bus.steps_done), 32'd3);

        bus.step_count = 8'd0;
        bus.step_btn   = 1'b1;
        capture(6);
        chk("step0_trace", ce_tr[31:0], 32'h2);
        chk("step0_done",  32'(bus.steps_done), 32'd1);

        // Run: pulses 8 cycles after entering RUN, then every 8.
        bus.run_btn = 1'b1;
        capture(20);
        chk("run_trace", ce_tr[31:0], 32'h10100);
        chk("run_state", 32'(st_tr[0]), 32'(ST_RUN));
        chk("run_done",  32'(bus.steps_done), 32'd2);
        bus.halt_btn = 1'b1;
        capture(12);
        chk("halt_trace", ce_tr[31:0], 32'h0);
        chk("halt_idle",  32'(st_tr[0]), 32'(ST_IDLE));
        chk("halt_done",  32'(bus.steps_done), 32'd2);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        bus.bp_en      = 1'b1;
        bus.bp_addr    = 16'h000C;
        bus.step_count = 8'd10;
        bus.step_btn   = 1'b1;
        capture(12);
        chk("bp_trace",  ce_tr[31:0], 32'h2A);
        chk("bp_t7",     32'(st_tr[6]), 32'(ST_STEP));
        chk("bp_t8",     32'(st_tr[7]), 32'(ST_BREAK));
        chk("bp_hit",    32'(bus.bp_hit), 32'd1);
        chk("bp_done",   32'(bus.steps_done), 32'd3);
        chk("bp_pc",     32'(pc_model), 32'h000C);

        bus.step_count = 8'd1;
        bus.step_btn   = 1'b1;
        capture(6);
        chk("bpstep_trace", ce_tr[31:0], 32'h2);
        chk("bpstep_state", 32'(bus.state), 32'(ST_IDLE));
        chk("bpstep_pc",    32'(pc_model), 32'h0010);
        chk("bpstep_bphit", 32'(bus.bp_hit), 32'd0);
        chk("bpstep_done",  32'(bus.steps_done), 32'd1);

        bus.bp_en    = 1'b0;
        bus.halt_btn = 1'b1;
        bus.run_btn  = 1'b1;
        capture(12);
        chk("haltrun_trace", ce_tr[31:0], 32'h0);
        chk("haltrun_s0",    32'(st_tr[0]),  32'(ST_IDLE));
        chk("haltrun_s11",   32'(st_tr[11]), 32'(ST_IDLE));

        bus.run_btn  = 1'b1;
        bus.step_btn = 1'b1;
        capture(10);
        chk("runstep_trace", ce_tr[31:0], 32'h100);
        chk("runstep_state", 32'(st_tr[0]), 32'(ST_RUN));
        chk("runstep_done",  32'(bus.steps_done), 32'd1);

        // Now in the CHECK cycle right after a run pulse.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_state", 32'(bus.state),  32'(ST_IDLE));
        chk("midrst_ce",    32'(bus.cpu_ce), 32'd0);
        chk("midrst_done",  32'(bus.steps_done), 32'd0);
        chk("midrst_bphit", 32'(bus.bp_hit), 32'd0);
        capture(10);
        chk("midrst_quiet", ce_tr[31:0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
